rob_wb_arb: RTL and testbench

ROB_WB_ARB -- requirements
Module: rob_wb_arb

---
 rtl/rob_wb_arb_if.sv | 39 +++
 rtl/rob_wb_arb.sv | 71 +++++++
 tb/tb_rob_wb_arb.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rob_wb_arb_if.sv
// rob_wb_arb_if: shared ROB-entry type plus the requester/ROB-write bundle of the writeback arbiter
// Contents:
//   rob_wb_arb_pkg::rob_entry_t  result payload carried from a unit to the ROB
//   rob_wb_arb_if                flush, req_valid/req_slot/req_data/req_ready (4 units),
//                                wr_valid/wr_slot/wr_data (2 ROB write ports), collision_err
//   modport slave                the arbiter side; modport master the unit/ROB side
package rob_wb_arb_pkg;
    typedef struct packed {
        logic        exception;
        logic [4:0]  dest;
        logic [31:0] value;
    } rob_entry_t;
endpackage

interface rob_wb_arb_if
    import rob_wb_arb_pkg::*;
#(
    parameter int ROB_DEPTHLOG2 = 4
);
    logic                     flush;
    logic [3:0]               req_valid;
    logic [ROB_DEPTHLOG2-1:0] req_slot [4];
    rob_entry_t               req_data [4];
    logic [3:0]               req_ready;
    logic [1:0]               wr_valid;
    logic [ROB_DEPTHLOG2-1:0] wr_slot [2];
    rob_entry_t               wr_data [2];
    logic                     collision_err;

    modport slave (
        input  flush, req_valid, req_slot, req_data,
        output req_ready, wr_valid, wr_slot, wr_data, collision_err
    );

    modport master (
        output flush, req_valid, req_slot, req_data,
        input  req_ready, wr_valid, wr_slot, wr_data, collision_err
    );
endinterface

// File: rtl/rob_wb_arb.sv
// rob_wb_arb: round-robin arbiter sharing 2 registered ROB write ports among 4 writeback units
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      rob_wb_arb_if.slave: flush, per-unit req_valid/req_slot/req_data and
//            combinational req_ready; registered wr_valid/wr_slot/wr_data[2]; sticky collision_err
module rob_wb_arb
    import rob_wb_arb_pkg::*;
#(
    parameter int ROB_DEPTHLOG2 = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    rob_wb_arb_if.slave   bus
);
    logic [1:0] rr_ptr;
    logic [3:0] cand;
    logic [1:0] g0, g1, idx;
    logic       g0_v, g1_v;

    // reset_n in the candidate mask keeps req_ready low for the whole reset window
    assign cand = bus.req_valid & {4{~bus.flush & reset_n}};

    // scan from rr_ptr: first candidate takes port 0, second takes port 1
    always_comb begin
        g0_v = 1'b0;
        g1_v = 1'b0;
        g0 = '0;
        g1 = '0;
        idx = '0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (cand[idx] && !g0_v) begin
                g0_v = 1'b1;
                g0 = idx;
            end else if (cand[idx] && !g1_v) begin
                g1_v = 1'b1;
                g1 = idx;
            end
        end
    end

    assign bus.req_ready = ({3'b0, g0_v} << g0) | ({3'b0, g1_v} << g1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
            bus.wr_valid <= '0;
            bus.wr_slot[0] <= '0;
            bus.wr_slot[1] <= '0;
            bus.wr_data[0] <= '0;
            bus.wr_data[1] <= '0;
            bus.collision_err <= 1'b0;
        end else begin
            bus.wr_valid <= {g1_v, g0_v};
            if (g0_v) begin
                bus.wr_slot[0] <= bus.req_slot[g0];
                bus.wr_data[0] <= bus.req_data[g0];
            end
            if (g1_v) begin
                bus.wr_slot[1] <= bus.req_slot[g1];
                bus.wr_data[1] <= bus.req_data[g1];
            end
            // the last unit granted in scan order is port 1's when both ports are used
            if (g0_v)
                rr_ptr <= (g1_v ? g1 : g0) + 2'd1;
            if (g0_v && g1_v && bus.req_slot[g0] == bus.req_slot[g1])
                bus.collision_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rob_wb_arb.sv
// tb_rob_wb_arb: table-driven check of grants, registered writes, pointer rotation, flush, collision and reset
module tb_rob_wb_arb;
    import rob_wb_arb_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    rob_wb_arb_if #(.ROB_DEPTHLOG2(4)) bus ();

    rob_wb_arb #(.ROB_DEPTHLOG2(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [3:0]      v;
        logic            fl;
        logic [3:0][3:0] s;
        logic [3:0]      er;
        logic [1:0]      ewv;
        logic [1:0]      eu0;
        logic [1:0]      eu1;
        logic [1:0]      err;
        logic            ecoll;
    } vec_t;

    vec_t tbl [13];

    function automatic rob_entry_t mk(input int r, input int u);
        rob_entry_t e;
        e.exception = u[0];
        e.dest = 5'(u + r);
        e.value = 32'hC0DE0000 | 32'(r << 4) | 32'(u);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int r, input logic [3:0] v, input logic fl, input logic [3:0][3:0] s);
        bus.req_valid = v;
        bus.flush = fl;
        for (int i = 0; i < 4; i++) begin
            bus.req_slot[i] = s[i];
            bus.req_data[i] = mk(r, i);
        end
    endtask

    initial begin
        //               valid    fl    slots u3..u0                       ready    wr    eu0   eu1   rr    coll
        tbl[0]  = '{4'b0000, 1'b0, {4'd0, 4'd0, 4'd0, 4'd0}, 4'b0000, 2'b00, 2'd0, 2'd0, 2'd0, 1'b0};
        tbl[1]  = '{4'b1111, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1}, 4'b0011, 2'b11, 2'd0, 2'd1, 2'd2, 1'b0};
        tbl[2]  = '{4'b1111, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1}, 4'b1100, 2'b11, 2'd2, 2'd3, 2'd0, 1'b0};
        tbl[3]  = '{4'b0100, 1'b0, {4'd0, 4'd7, 4'd0, 4'd0}, 4'b0100, 2'b01, 2'd2, 2'd0, 2'd3, 1'b0};
        tbl[4]  = '{4'b1111, 1'b1, {4'd4, 4'd3, 4'd2, 4'd1}, 4'b0000, 2'b00, 2'd0, 2'd0, 2'd3, 1'b0};
        tbl[5]  = '{4'b1111, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1}, 4'b1001, 2'b11, 2'd3, 2'd0, 2'd1, 1'b0};
        tbl[6]  = '{4'b1011, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1}, 4'b1010, 2'b11, 2'd1, 2'd3, 2'd0, 1'b0};
        tbl[7]  = '{4'b1000, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1}, 4'b1000, 2'b01, 2'd3, 2'd0, 2'd0, 1'b0};
        tbl[8]  = '{4'b0000, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1}, 4'b0000, 2'b00, 2'd0, 2'd0, 2'd0, 1'b0};
        tbl[9]  = '{4'b1011, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1}, 4'b0011, 2'b11, 2'd0, 2'd1, 2'd2, 1'b0};
        tbl[10] = '{4'b1011, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1}, 4'b1001, 2'b11, 2'd3, 2'd0, 2'd1, 1'b0};
        tbl[11] = '{4'b0011, 1'b0, {4'd0, 4'd0, 4'd5, 4'd5}, 4'b0011, 2'b11, 2'd1, 2'd0, 2'd1, 1'b1};
        tbl[12] = '{4'b0000, 1'b0, {4'd0, 4'd0, 4'd5, 4'd5}, 4'b0000, 2'b00, 2'd0, 2'd0, 2'd1, 1'b1};

        drive(0, 4'b1111, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1});
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("ready_in_reset", 64'(bus.req_ready), 64'h0);
        chk("wr_valid_in_reset", 64'(bus.wr_valid), 64'h0);
        chk("wr_slot0_in_reset", 64'(bus.wr_slot[0]), 64'h0);
        chk("wr_data1_in_reset", 64'(bus.wr_data[1]), 64'h0);
        chk("coll_in_reset", 64'(bus.collision_err), 64'h0);
        drive(0, 4'b0000, 1'b0, '0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk("idle_ready", 64'(bus.req_ready), 64'h0);
            chk("idle_wr_valid", 64'(bus.wr_valid), 64'h0);
            chk("idle_coll", 64'(bus.collision_err), 64'h0);
            chk("idle_rr", 64'(dut.rr_ptr), 64'h0);
        end
        @(posedge clock);
        #1;

        for (int r = 0; r < 13; r++) begin
            drive(r, tbl[r].v, tbl[r].fl, tbl[r].s);
            @(negedge clock);
            chk($sformatf("ready[%0d]", r), 64'(bus.req_ready), 64'(tbl[r].er));
            @(posedge clock);
            #1;
            chk($sformatf("wr_valid[%0d]", r), 64'(bus.wr_valid), 64'(tbl[r].ewv));
            chk($sformatf("rr_ptr[%0d]", r), 64'(dut.rr_ptr), 64'(tbl[r].err));
            chk($sformatf("coll[%0d]", r), 64'(bus.collision_err), 64'(tbl[r].ecoll));
            if (tbl[r].ewv[0]) begin
                chk($sformatf("wr_slot0[%0d]", r), 64'(bus.wr_slot[0]), 64'(tbl[r].s[tbl[r].eu0]));
                chk($sformatf("wr_data0[%0d]", r), 64'(bus.wr_data[0]), 64'(mk(r, int'(tbl[r].eu0))));
            end
            if (tbl[r].ewv[1]) begin
                chk($sformatf("wr_slot1[%0d]", r), 64'(bus.wr_slot[1]), 64'(tbl[r].s[tbl[r].eu1]));
                chk($sformatf("wr_data1[%0d]", r), 64'(bus.wr_data[1]), 64'(mk(r, int'(tbl[r].eu1))));
            end
        end

        // reset asserted mid-cycle with a pair of writes pending: they are dropped and the flag clears
        drive(20, 4'b1111, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1});
        @(posedge clock);
        #1;
        chk("pre_reset_wr_valid", 64'(bus.wr_valid), 64'h3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_wr_valid", 64'(bus.wr_valid), 64'h0);
        chk("async_wr_slot0", 64'(bus.wr_slot[0]), 64'h0);
        chk("async_coll", 64'(bus.collision_err), 64'h0);
        chk("async_rr", 64'(dut.rr_ptr), 64'h0);
        chk("async_ready", 64'(bus.req_ready), 64'h0);
        drive(21, 4'b0000, 1'b0, '0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("post_reset_wr_valid", 64'(bus.wr_valid), 64'h0);
        drive(22, 4'b0100, 1'b0, {4'd0, 4'd9, 4'd0, 4'd0});
        @(negedge clock);
        chk("first_arb_ready", 64'(bus.req_ready), 64'h4);
        @(posedge clock);
        #1;
        chk("first_arb_wr_valid", 64'(bus.wr_valid), 64'h1);
        chk("first_arb_slot", 64'(bus.wr_slot[0]), 64'h9);
        chk("first_arb_data", 64'(bus.wr_data[0]), 64'(mk(22, 2)));
        chk("first_arb_rr", 64'(dut.rr_ptr), 64'h3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
